prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_pkg.sv | 29 ++
 rtl/lfsr_fb.sv | 11 +
 rtl/prbs_checker.sv | 157 +++++++++++++++
 tb/tb_prbs_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the 32-bit PRBS checker and its companion generator:
// sequence width, feedback tap positions and checker state encodings.
package prbs_pkg;

  localparam int SEQ_W = 32;

  localparam int TAP_A = 31;
  localparam int TAP_B = 30;
  localparam int TAP_C = 29;
  localparam int TAP_D = 27;
  localparam int TAP_E = 25;
  localparam int TAP_F = 0;

  localparam logic [SEQ_W-1:0] TAP_MASK = (SEQ_W'(1) << TAP_A) | (SEQ_W'(1) << TAP_B) |
                                          (SEQ_W'(1) << TAP_C) | (SEQ_W'(1) << TAP_D) |
                                          (SEQ_W'(1) << TAP_E) | (SEQ_W'(1) << TAP_F);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_t;

  // Next bit entering R[31]; the generator advances with R <= {prbs_fb(R), R[31:1]}.
  function automatic logic prbs_fb(input logic [SEQ_W-1:0] r);
    return ^(r & TAP_MASK);
  endfunction

endpackage

// File: rtl/lfsr_fb.sv
// Combinational feedback of the 32-bit PRBS register: XOR of the tapped bits.
module lfsr_fb
  import prbs_pkg::*;
(
  input  logic [SEQ_W-1:0] r,
  output logic             fb
);

  assign fb = ^(r & TAP_MASK);

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: loads 32 received bits, verifies LOCK_CNT flywheel predictions,
// then counts errors while locked and drops lock on too many errors per window.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 32,
  parameter int LOSS_WIN = 64,
  parameter int LOSS_THR = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        din,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic [1:0]  state
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int EW = $clog2(LOSS_THR + 1);

  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(LOSS_WIN - 1);
  localparam logic [EW-1:0] ERR_THR    = EW'(LOSS_THR);

  prbs_state_t      state_q, state_d;
  logic [SEQ_W-1:0] r_q, r_d;
  logic [4:0]       load_q, load_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WW-1:0]    win_q, win_d;
  logic [EW-1:0]    win_err_q, win_err_d;
  logic             err_q, err_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             locked_q;

  logic             fb_bit;
  logic             mismatch;
  logic [SEQ_W-1:0] r_load;
  logic [SEQ_W-1:0] r_fly;
  logic [EW-1:0]    win_err_inc;

  lfsr_fb u_fb (
    .r  (r_q),
    .fb (fb_bit)
  );

  assign mismatch    = din ^ fb_bit;
  assign r_load      = {din, r_q[SEQ_W-1:1]};
  assign r_fly       = {fb_bit, r_q[SEQ_W-1:1]};
  assign win_err_inc = win_err_q + EW'(mismatch);

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    load_d    = load_q;
    match_d   = match_q;
    win_d     = win_q;
    win_err_d = win_err_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    if (enable) begin
      case (state_q)
        ST_HUNT: begin
          r_d    = r_load;
          load_d = load_q + 5'd1;
          // An all-zero register is the LFSR lock-up state; keep hunting.
          if (load_q == 5'd31) begin
            load_d = 5'd0;
            if (r_load != '0) begin
              state_d = ST_VERIFY;
              match_d = '0;
            end
          end
        end

        ST_VERIFY: begin
          r_d = r_fly;
          if (mismatch) begin
            state_d = ST_HUNT;
            load_d  = 5'd0;
            match_d = '0;
          end else if (match_q == MATCH_LAST) begin
            state_d   = ST_LOCKED;
            match_d   = '0;
            win_d     = '0;
            win_err_d = '0;
          end else begin
            match_d = match_q + MW'(1);
          end
        end

        ST_LOCKED: begin
          r_d   = r_fly;
          err_d = mismatch;
          if (mismatch && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
          // Error is counted before the threshold test; window end restarts both counters.
          if (mismatch && (win_err_inc == ERR_THR)) begin
            state_d   = ST_HUNT;
            load_d    = 5'd0;
            match_d   = '0;
            win_d     = '0;
            win_err_d = '0;
          end else if (win_q == WIN_LAST) begin
            win_d     = '0;
            win_err_d = '0;
          end else begin
            win_d     = win_q + WW'(1);
            win_err_d = win_err_inc;
          end
        end

        default: begin
          state_d = ST_HUNT;
          load_d  = 5'd0;
          match_d = '0;
          win_d   = '0;
          win_err_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HUNT;
      r_q       <= '0;
      load_q    <= 5'd0;
      match_q   <= '0;
      win_q     <= '0;
      win_err_q <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= 16'd0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      load_q    <= load_d;
      match_q   <= match_d;
      win_q     <= win_d;
      win_err_q <= win_err_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      locked_q  <= (state_d == ST_LOCKED);
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign state   = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a behavioural reference predicts every
// registered output cycle by cycle, plus scenario-level checks on lock timing.
module tb_prbs_checker;
  import prbs_pkg::*;

  localparam int LOCK_CNT = 32;
  localparam int LOSS_WIN = 64;
  localparam int LOSS_THR = 8;

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic [1:0]  state;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        din;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb[$];

  // reference model state
  int          m_state;
  logic [31:0] m_r;
  int          m_load, m_match, m_win, m_werr, m_ecnt;
  logic        m_err;

  // generator and scenario bookkeeping
  logic [31:0] gen_r;
  int          nbits;
  int          lock_at;
  int          err_pulses;
  int          max_state;

  always #5 clk = ~clk;

  prbs_checker #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_WIN (LOSS_WIN),
    .LOSS_THR (LOSS_THR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .din     (din),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt),
    .state   (state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rv, input logic ev, input logic dv);
    logic fbm;
    if (rv) begin
      m_state = 0; m_r = '0; m_load = 0; m_match = 0;
      m_win = 0; m_werr = 0; m_err = 1'b0; m_ecnt = 0;
    end else begin
      m_err = 1'b0;
      if (ev) begin
        fbm = m_r[31] ^ m_r[30] ^ m_r[29] ^ m_r[27] ^ m_r[25] ^ m_r[0];
        case (m_state)
          0: begin
            m_r = {dv, m_r[31:1]};
            m_load++;
            if (m_load == 32) begin
              m_load = 0;
              if (m_r != 32'd0) begin m_state = 1; m_match = 0; end
            end
          end
          1: begin
            m_r = {fbm, m_r[31:1]};
            if (dv != fbm) begin
              m_state = 0; m_load = 0; m_match = 0;
            end else begin
              m_match++;
              if (m_match == LOCK_CNT) begin
                m_state = 2; m_match = 0; m_win = 0; m_werr = 0;
              end
            end
          end
          default: begin
            m_r = {fbm, m_r[31:1]};
            m_win++;
            if (dv != fbm) begin
              m_err = 1'b1;
              if (m_ecnt < 65535) m_ecnt++;
              m_werr++;
            end
            if (dv != fbm && m_werr == LOSS_THR) begin
              m_state = 0; m_load = 0; m_match = 0; m_win = 0; m_werr = 0;
            end else if (m_win == LOSS_WIN) begin
              m_win = 0; m_werr = 0;
            end
          end
        endcase
      end
    end
  endtask

  // One clock: drive at negedge, predict and queue, then observe after the edge.
  task automatic drive(input logic rv, input logic ev, input logic dv);
    exp_t e;
    @(negedge clk);
    rst = rv; enable = ev; din = dv;
    model_step(rv, ev, dv);
    e.locked  = (m_state == 2);
    e.err     = m_err;
    e.err_cnt = 16'(m_ecnt);
    e.state   = 2'(m_state);
    sb.push_back(e);
    @(posedge clk);
    #2;
    if (ev && !rv) nbits++;
    if (err) err_pulses++;
    if (locked && lock_at < 0) lock_at = nbits;
    if (int'(state) > max_state) max_state = int'(state);
  endtask

  task automatic send(input logic inv);
    logic b;
    b = gen_r[0];
    gen_r = {prbs_fb(gen_r), gen_r[31:1]};
    drive(1'b0, 1'b1, b ^ inv);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    nbits = 0; lock_at = -1; err_pulses = 0; max_state = 0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("sb_locked", 32'(locked), 32'(e.locked));
      check("sb_err", 32'(err), 32'(e.err));
      check("sb_err_cnt", 32'(err_cnt), 32'(e.err_cnt));
      check("sb_state", 32'(state), 32'(e.state));
    end
  end

  initial begin
    int pulses0;
    int guard;
    rst = 1'b1; enable = 1'b0; din = 1'b0;

    // clean stream from the generator after its reset
    gen_r = 32'hACE1_0001;
    do_reset(2);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    for (int i = 0; i < 200; i++) send(1'b0);
    check("s1_lock_at", lock_at, 64);
    check("s1_err_pulses", err_pulses, 0);
    check("s1_err_cnt", 32'(err_cnt), 32'd0);

    // single inverted bit while locked
    pulses0 = err_pulses;
    send(1'b1);
    for (int i = 0; i < 20; i++) send(1'b0);
    check("s2_err_pulses", err_pulses - pulses0, 1);
    check("s2_err_cnt", 32'(err_cnt), 32'd1);
    check("s2_locked", 32'(locked), 32'd1);

    // eight errors inside one window drop lock; relock 64 bits later
    do_reset(1);
    for (int i = 0; i < 100; i++) send(1'b0);
    check("s3_locked_pre", 32'(locked), 32'd1);
    for (int i = 0; i < 7; i++) send(1'b1);
    check("s3_locked_7th", 32'(locked), 32'd1);
    send(1'b1);
    check("s3_locked_8th", 32'(locked), 32'd0);
    check("s3_state_8th", 32'(state), 32'(ST_HUNT));
    check("s3_err_cnt", 32'(err_cnt), 32'd8);
    nbits = 0; lock_at = -1;
    for (int i = 0; i < 80; i++) send(1'b0);
    check("s3_relock_at", lock_at, 64);
    check("s3_err_cnt_kept", 32'(err_cnt), 32'd8);

    // all-zero stream never leaves HUNT
    do_reset(1);
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b0);
    check("s4_state", 32'(state), 32'(ST_HUNT));
    check("s4_locked", 32'(locked), 32'd0);
    check("s4_max_state", max_state, 0);

    // error during VERIFY returns to HUNT without counting
    do_reset(1);
    for (int i = 1; i <= 120; i++) begin
      send(i == 40);
      if (i == 40) begin
        check("s5_state_hunt", 32'(state), 32'(ST_HUNT));
        check("s5_err", 32'(err), 32'd0);
      end
    end
    check("s5_err_cnt", 32'(err_cnt), 32'd0);
    check("s5_lock_at", lock_at, 104);

    // reset while locked with five errors, random enable afterwards
    do_reset(1);
    for (int i = 0; i < 70; i++) send(1'b0);
    for (int i = 0; i < 5; i++) begin send(1'b1); send(1'b0); send(1'b0); end
    check("s6_err_cnt_pre", 32'(err_cnt), 32'd5);
    check("s6_locked_pre", 32'(locked), 32'd1);
    do_reset(1);
    check("s6_rst_locked", 32'(locked), 32'd0);
    check("s6_rst_err", 32'(err), 32'd0);
    check("s6_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("s6_rst_state", 32'(state), 32'd0);
    guard = 0;
    while (nbits < 100 && guard < 1000) begin
      guard++;
      if ($urandom_range(0, 1) == 1) send(1'b0);
      else drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    check("s6_bits_done", 32'(nbits >= 100), 32'd1);
    check("s6_relock_at", lock_at, 64);

    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
